// File: rtl/ram_sp_stream_ctrl_if.sv
// rtl/ram_sp_stream_ctrl_if.sv - stream, dump-control and RAM-port bundle for ram_sp_stream_ctrl
interface ram_sp_stream_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          start_dump;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          full;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_write_en;
  logic [DW-1:0] ram_data_out;

  // master: the controller, which owns every RAM port
  modport master (
    input  in_data, in_valid, start_dump, out_ready, ram_data_out,
    output in_ready, out_data, out_valid, busy, full,
           ram_addr, ram_data_in, ram_write_en
  );

  modport slave (
    output in_data, in_valid, start_dump, out_ready, ram_data_out,
    input  in_ready, out_data, out_valid, busy, full,
           ram_addr, ram_data_in, ram_write_en
  );
endinterface

// File: rtl/ram_sp_stream_ctrl.sv
// rtl/ram_sp_stream_ctrl.sv - loads a byte stream into a 1-cycle-read RAM and dumps it back in order
// Optional CHECKSUM_EN adds a running XOR of accepted bytes on port checksum.
module ram_sp_stream_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_sp_stream_ctrl_if.master bus
`ifdef CHECKSUM_EN
  ,
  output logic [DW-1:0]       checksum
`endif
);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {S_LOAD, S_READ, S_WAIT, S_OUT} state_t;

  state_t        r_state;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [DW-1:0] r_out_data;
  logic          r_out_valid;

  logic          w_in_ready;
  logic          w_wr;
  logic          w_last;
  logic [AW:0]   w_count_next;

  assign w_in_ready   = (r_state == S_LOAD) && (r_count < LP_DEPTH);
  assign w_wr         = w_in_ready & bus.in_valid;
  assign w_count_next = r_count + {{AW{1'b0}}, w_wr};
  assign w_last       = ({1'b0, r_rd_ptr} == (r_count - LP_ONE));

  assign bus.in_ready     = w_in_ready;
  assign bus.ram_write_en = w_wr;
  // Write address is the fill level; outside LOAD the read pointer drives the RAM.
  assign bus.ram_addr     = (r_state == S_LOAD) ? r_count[AW-1:0] : r_rd_ptr;
  assign bus.ram_data_in  = w_wr ? bus.in_data : '0;
  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.busy         = (r_state != S_LOAD);
  assign bus.full         = (r_count == LP_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_count <= w_count_next;
          // A byte written in the start_dump cycle is part of the dump.
          if (bus.start_dump && (w_count_next != '0)) begin
            r_rd_ptr <= '0;
            r_state  <= S_READ;
          end
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_out_data  <= bus.ram_data_out;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_count <= '0;
              r_state <= S_LOAD;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
              r_state  <= S_READ;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (r_state == S_OUT && bus.out_ready && w_last) begin
      r_checksum <= '0;
    end else if (w_wr) begin
      r_checksum <= r_checksum ^ bus.in_data;
    end
  end

  assign checksum = r_checksum;
`endif
endmodule

// File: tb/tb_ram_sp_stream_ctrl.sv
// tb/tb_ram_sp_stream_ctrl.sv - self-checking bench for ram_sp_stream_ctrl with a behavioural RAM and queue model
module tb_ram_sp_stream_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  logic [7:0] model[$];
  logic [7:0] csum = 8'h00;
  logic [7:0] mem[16];

  ram_sp_stream_ctrl_if #(.DW(DW), .AW(AW)) bus ();
`ifdef CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_sp_stream_ctrl #(.DW(DW), .AW(AW), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    chk("wr_in_ready", bus.in_ready, 1);
    chk("wr_en", bus.ram_write_en, 1);
    chk("wr_addr", bus.ram_addr, model.size());
    chk("wr_din", bus.ram_data_in, b);
    model.push_back(b);
    csum ^= b;
    step();
    bus.in_valid = 1'b0;
`ifdef CHECKSUM_EN
    chk("wr_checksum", checksum, csum);
`endif
  endtask

  task automatic dump(input int stall_idx, input int stall_len, input bit with_wr, input logic [7:0] wb);
    logic [7:0] exp[$];
    int lat;
    bus.start_dump = 1'b1;
    if (with_wr) begin
      bus.in_valid = 1'b1;
      bus.in_data  = wb;
    end
    @(negedge clk);
    chk("dump_c0_wen", bus.ram_write_en, with_wr);
    if (with_wr) begin
      model.push_back(wb);
      csum ^= wb;
    end
    step();
    bus.start_dump = 1'b0;
    bus.in_valid   = 1'b0;
    exp = model;
    model.delete();
    foreach (exp[i]) begin
      bus.out_ready = (i == stall_idx) ? 1'b0 : 1'b1;
      lat = 1;
      @(negedge clk);
      chk("dump_busy", bus.busy, 1);
      while (bus.out_valid !== 1'b1 && lat < 8) begin
        step();
        lat++;
        @(negedge clk);
      end
      chk("dump_latency", lat, 3);
      chk("dump_data", bus.out_data, exp[i]);
      if (i == stall_idx) begin
        for (int s = 1; s <= stall_len; s++) begin
          step();
          if (s == stall_len) bus.out_ready = 1'b1;
          @(negedge clk);
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, exp[i]);
        end
      end
      step();
    end
    @(negedge clk);
    chk("end_in_ready", bus.in_ready, 1);
    chk("end_busy", bus.busy, 0);
    chk("end_out_valid", bus.out_valid, 0);
    chk("end_full", bus.full, 0);
    csum = 8'h00;
`ifdef CHECKSUM_EN
    chk("end_checksum", checksum, csum);
`endif
    step();
  endtask

  initial begin
    int n;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.start_dump = 1'b0;
    bus.out_ready  = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_wen", bus.ram_write_en, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_din", bus.ram_data_in, 0);
`ifdef CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // Basic three-byte load and dump
    wr(8'h11); wr(8'h22); wr(8'h33);
    dump(-1, 0, 1'b0, 8'h00);

    // Fill to capacity; the 17th offer must be refused
    for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB0;
    @(negedge clk);
    chk("full_flag", bus.full, 1);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_no_wen", bus.ram_write_en, 0);
    step();
    bus.in_valid = 1'b0;
    dump(-1, 0, 1'b0, 8'h00);

    // Backpressure on the second byte
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    dump(1, 5, 1'b0, 8'h00);

    // start_dump on an empty store is ignored
    bus.start_dump = 1'b1;
    @(negedge clk);
    chk("empty_wen", bus.ram_write_en, 0);
    step();
    bus.start_dump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_busy", bus.busy, 0);
      chk("empty_in_ready", bus.in_ready, 1);
      step();
    end

    // start_dump together with the only write
    dump(-1, 0, 1'b1, 8'h5A);

`ifdef CHECKSUM_EN
    wr(8'h0F); wr(8'hF0); wr(8'h3C);
    chk("checksum_c3", checksum, 32'hC3);
    dump(-1, 0, 1'b0, 8'h00);
`endif

    // Reset while the first read is in WAIT
    wr(8'hC1); wr(8'hC2);
    bus.start_dump = 1'b1;
    step();
    bus.start_dump = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_wait_out_valid", bus.out_valid, 0);
    chk("rst_wait_busy", bus.busy, 0);
    chk("rst_wait_in_ready", bus.in_ready, 1);
    chk("rst_wait_addr", bus.ram_addr, 0);
    model.delete();
    csum = 8'h00;
`ifdef CHECKSUM_EN
    chk("rst_wait_checksum", checksum, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    wr(8'h77);
    dump(-1, 0, 1'b0, 8'h00);

    // Randomised loads with random backpressure
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) wr(8'($urandom));
      dump(int'($urandom_range(0, n - 1)), int'($urandom_range(1, 4)),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
